cntdn_timer: RTL
================

// Module: cntdn_timer
// PURPOSE
//  Loadable down-counter / one-shot timer; the counting complement of the free-running up-counter.
//  Loaded with a value on a start strobe and decremented once per prescaled tick.
//  Pulses done for one cycle when the count reaches zero.
//  Sits between control logic and timed datapath events (delays, timeouts, pulse stretching).
// PARAMETERS
//  WIDTH     4   width of load_val and count (max load 2**WIDTH-1)
//  PRESCALE  1   clk cycles per decrement; legal range >=1
// PORTS
//  clk       in   1      rising-edge clock; sole clock domain
//  rst       in   1      synchronous, active-high reset
//  load_val  in   WIDTH  start value, sampled on an accepted start
//  start     in   1      start request; accepted only in IDLE or DONE
//  pause     in   1      freezes the count and prescaler while high in RUN
//  abort     in   1      cancels a run without producing done
//  count     out  WIDTH  current count value (registered)
//  busy      out  1      high while in RUN
//  done      out  1      single-cycle completion pulse (high in DONE)
//  zero      out  1      (count == 0), combinational from the count register
// BEHAVIOUR
//  Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
//  Reset (also mid-operation, overrides every input):
//   state=IDLE, count=0, prescaler=0, busy=0, done=0, zero=1.
//  FSM states: IDLE, RUN, DONE.
//   Outputs decode from state: busy=(state==RUN), done=(state==DONE).
//  IDLE/DONE:
//   - start & !abort & load_val!=0 -> RUN; count<=load_val; prescaler<=0.
//   - start & !abort & load_val==0 -> DONE (done pulses; zero-length run).
//   - Otherwise IDLE/DONE -> IDLE; count holds.
//  RUN: tick = (prescaler==PRESCALE-1) & !pause.
//   - pause high: prescaler and count hold; state stays RUN.
//   - No tick: prescaler increments.
//   - Tick: prescaler<=0, count<=count-1.
//   - Tick with count==1: count<=0, state->DONE.
//  abort in RUN -> IDLE, count<=0, no done pulse. abort has priority over pause and tick.
//  start while in RUN is ignored; load_val is not resampled.
//  Priority: rst > abort > start > pause > tick.
//  Timing: start accepted at edge 0 with load N -> count==0 and state==DONE after edge N*PRESCALE.
//   done is high exactly for the following cycle.
//   Each pause-high cycle in RUN delays done by exactly one cycle.
//  Width: count never wraps below 0. Prescaler width is $clog2(PRESCALE)+1.
// CONFIGURATION
//  CNTDN_AUTO_RELOAD_EN defined:
//   - At the terminal tick, the FSM enters DONE for one cycle (done=1, count=0).
//   - In the DONE cycle, load_val is sampled and the FSM re-enters RUN with no start required.
//   - If load_val==0 at that point -> IDLE. abort in DONE -> IDLE.
//   - Period = N*PRESCALE+1 cycles.
//  CNTDN_AUTO_RELOAD_EN undefined: one-shot only; DONE -> IDLE unless start is asserted.
// TESTING
//  1. Assert rst 2 cycles, inputs idle -> count=0, busy=0, done=0, zero=1.
//  2. WIDTH=4, PRESCALE=1, load_val=5, start 1 cycle -> count 5,4,3,2,1,0 on consecutive edges.
//     done high 1 cycle when count==0; busy low.
//  3. PRESCALE=3, load_val=2 -> done 6 cycles after the start edge.
//     Pause for 4 cycles mid-run -> done 10 cycles after the start edge.
//  4. load_val=9, abort at count=4 -> next edge count=0, busy=0; done never asserts.
//     start+abort together in IDLE -> stays IDLE.
//  5. load_val=15 run; start with load_val=3 while busy -> ignored, 15 decrements complete.
//     load_val=0 start -> done next cycle, busy never high.
//  6. rst at count=7 mid-run -> reset values next edge.
//     With CNTDN_AUTO_RELOAD_EN, load_val=2, PRESCALE=1 -> done pulses every 3 cycles until load_val=0.

Source files
------------

// File: rtl/cntdn_timer.sv
// cntdn_timer: loadable one-shot down-counter with prescaled decrement, pause and abort.
// Define CNTDN_AUTO_RELOAD_EN to reload from load_val automatically in the DONE cycle.
module cntdn_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);
  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
`ifdef CNTDN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state;
  logic [PW-1:0]   pre;
  logic            accept, reload;
  assign accept = start & ~abort;
  assign reload = AUTO & (state == DONE) & ~abort;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign zero   = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pre   <= '0;
    end else if (state == RUN) begin
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (!pause) begin
        if (pre == PMAX) begin
          pre   <= '0;
          count <= count - WIDTH'(1);
          if (count == WIDTH'(1)) state <= DONE;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end else if (accept || reload) begin
      // a zero load is a zero-length run when requested, but ends an auto-reload chain
      count <= load_val;
      pre   <= '0;
      state <= (load_val != '0) ? RUN : accept ? DONE : IDLE;
    end else begin
      state <= IDLE;
    end
  end
endmodule
